// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller.
//   SEG_A..SEG_G : bit position of each segment inside a 7-bit segment word
//   SEG_BLANK    : active-high segment word with every segment dark
//   SEG_TABLE    : active-high hex font, entry n = glyph for nibble n
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Listed from entry 15 (F) down to entry 0 so that SEG_TABLE[n] is glyph n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
//   nibble : hex digit to display
//   blank  : force all segments dark (leading-zero suppression)
//   seg    : segment word, bit0 = a .. bit6 = g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment display controller with frame-synchronous value update,
// leading-zero blanking, per-digit decimal point and 16-level PWM brightness.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   value, dp     : hex nibbles (digit 0 = [3:0]) and decimal points, captured on value_we
//   value_we      : single-cycle write strobe
//   lz_blank      : live leading-zero blanking enable
//   brightness    : live duty select, 0 = 1/16 .. 15 = full
//   update_ack    : pulse in the first cycle a written value is visible
//   frame_strobe  : pulse one cycle after the counters pass digit 0 / slot 0
//   seg_static    : per-digit segments (static mode), digit n = [7n+6:7n]
//   seg_mux, dp_mux, dig_sel : scanned segment bus, dp and one-hot digit select (multiplexed mode)
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1024,
    parameter int MULTIPLEX  = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  value_we,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic                  update_ack,
    output logic                  frame_strobe,
    output logic [7*DIGITS-1:0]   seg_static,
    output logic [6:0]            seg_mux,
    output logic                  dp_mux,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int       SLOT_W = $clog2(SCAN_DIV);
    localparam int       IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int       NDEC   = (MULTIPLEX != 0) ? 1 : DIGITS;
    localparam logic     POL    = (ACTIVE_LOW != 0);

    // ---------------- timing counters ----------------
    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  dig_idx;
    logic              slot_wrap;
    logic              frame_bnd;

    assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign frame_bnd = slot_wrap && (dig_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else begin
            // SCAN_DIV is a power of two, so the slot counter wraps by overflow.
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_wrap) begin
                dig_idx <= frame_bnd ? '0 : dig_idx + 1'b1;
            end
        end
    end

    // ---------------- pending / active value handshake ----------------
    logic [4*DIGITS-1:0] pend_val, act_val, act_val_nxt;
    logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
    logic                pend_flag;
    logic                load_act;

    assign load_act = frame_bnd && (value_we || pend_flag);

    // A write landing on the boundary cycle itself goes straight to active.
    always_comb begin
        act_val_nxt = act_val;
        act_dp_nxt  = act_dp;
        if (frame_bnd && value_we) begin
            act_val_nxt = value;
            act_dp_nxt  = dp;
        end else if (frame_bnd && pend_flag) begin
            act_val_nxt = pend_val;
            act_dp_nxt  = pend_dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_val   <= '0;
            act_dp    <= '0;
        end else begin
            if (value_we) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            pend_flag <= frame_bnd ? 1'b0 : (pend_flag | value_we);
            act_val   <= act_val_nxt;
            act_dp    <= act_dp_nxt;
        end
    end

    // ---------------- blanking, PWM and digit selection ----------------
    // The output stage is fed from the value that active takes on this edge,
    // so the first update_ack cycle already shows the new segments.
    logic [DIGITS-1:0] blank;
    logic              zero_above;
    logic              lit_phase;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int n = DIGITS - 1; n >= 1; n--) begin
            zero_above = zero_above && (act_val_nxt[4*n +: 4] == 4'h0);
            blank[n]   = lz_blank && zero_above;
        end
    end

    // slot_cnt < (brightness+1)*(SCAN_DIV/16) reduces to comparing the top nibble.
    assign lit_phase = (slot_cnt[SLOT_W-1 -: 4] <= brightness);

    assign cur_nib   = act_val_nxt[4*dig_idx +: 4];
    assign cur_dp    = act_dp_nxt[dig_idx];
    assign cur_blank = blank[dig_idx];

    logic [NDEC-1:0][6:0] dec_seg;
    logic [7*DIGITS-1:0]  static_seg;

    for (genvar i = 0; i < NDEC; i++) begin : g_dec
        seg7_decode u_dec (
            .nibble (MULTIPLEX != 0 ? cur_nib   : act_val_nxt[4*i +: 4]),
            .blank  (MULTIPLEX != 0 ? cur_blank : blank[i]),
            .seg    (dec_seg[i])
        );
    end

    if (MULTIPLEX != 0) begin : g_mux_mode
        assign static_seg = '0;
    end else begin : g_static_mode
        assign static_seg = dec_seg;
    end

    logic [7*DIGITS-1:0] seg_static_p0;
    logic [6:0]          seg_mux_p0;
    logic                dp_mux_p0;
    logic [DIGITS-1:0]   dig_sel_p0;
    logic                frame_strobe_p0;

    always_comb begin
        seg_static_p0 = '0;
        seg_mux_p0    = '0;
        dp_mux_p0     = 1'b0;
        dig_sel_p0    = '0;
        if (lit_phase) begin
            if (MULTIPLEX != 0) begin
                seg_mux_p0 = dec_seg[0];
                dp_mux_p0  = cur_dp;
                dig_sel_p0 = DIGITS'(1) << dig_idx;
            end else begin
                seg_static_p0 = static_seg;
            end
        end
    end

    assign frame_strobe_p0 = (slot_cnt == '0) && (dig_idx == '0);

    // ---------------- output registers (polarity applied here) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_static   <= {7*DIGITS{POL}};
            seg_mux      <= {7{POL}};
            dp_mux       <= POL;
            dig_sel      <= {DIGITS{POL}};
            update_ack   <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            seg_static   <= seg_static_p0 ^ {7*DIGITS{POL}};
            seg_mux      <= seg_mux_p0 ^ {7{POL}};
            dp_mux       <= dp_mux_p0 ^ POL;
            dig_sel      <= dig_sel_p0 ^ {DIGITS{POL}};
            update_ack   <= load_act;
            frame_strobe <= frame_strobe_p0;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench: a static-mode and a multiplexed-mode instance share one
// stimulus stream; a cycle-count based reference model predicts every output.
module tb_seg7_display_ctrl;

    localparam int DIG   = 4;
    localparam int DIV   = 16;
    localparam int UNIT  = DIV / 16;
    localparam int FRAME = DIG * DIV;

    localparam logic [27:0] E_1A3F = {~7'h06, ~7'h77, ~7'h4F, ~7'h71};
    localparam logic [27:0] E_0040 = {7'h7F, 7'h7F, ~7'h66, ~7'h3F};
    localparam logic [27:0] E_0000 = {7'h7F, 7'h7F, 7'h7F, ~7'h3F};
    localparam logic [27:0] E_1234 = {~7'h06, ~7'h5B, ~7'h4F, ~7'h66};
    localparam logic [27:0] E_5678 = {~7'h6D, ~7'h7D, ~7'h07, ~7'h7F};
    localparam logic [27:0] E_9999 = {~7'h6F, ~7'h6F, ~7'h6F, ~7'h6F};

    logic        clk;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        value_we;
    logic        lz_blank;
    logic [3:0]  brightness;

    logic        ack_s, fs_s, dp_mux_s, ack_m, fs_m, dp_mux_m;
    logic [27:0] seg_static_s, seg_static_m;
    logic [6:0]  seg_mux_s, seg_mux_m;
    logic [3:0]  dig_sel_s, dig_sel_m;

    seg7_display_ctrl #(.DIGITS(DIG), .SCAN_DIV(DIV), .MULTIPLEX(0), .ACTIVE_LOW(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .value(value), .dp(dp), .value_we(value_we),
        .lz_blank(lz_blank), .brightness(brightness), .update_ack(ack_s),
        .frame_strobe(fs_s), .seg_static(seg_static_s), .seg_mux(seg_mux_s),
        .dp_mux(dp_mux_s), .dig_sel(dig_sel_s)
    );

    seg7_display_ctrl #(.DIGITS(DIG), .SCAN_DIV(DIV), .MULTIPLEX(1), .ACTIVE_LOW(1)) dut_m (
        .clk(clk), .reset_n(reset_n), .value(value), .dp(dp), .value_we(value_we),
        .lz_blank(lz_blank), .brightness(brightness), .update_ack(ack_m),
        .frame_strobe(fs_m), .seg_static(seg_static_m), .seg_mux(seg_mux_m),
        .dp_mux(dp_mux_m), .dig_sel(dig_sel_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Digit n is suppressed when it and every digit above it are zero.
    function automatic bit is_blank(input logic [15:0] v, input int n, input logic lz);
        return lz && (n > 0) && ((v >> (4 * n)) == 16'h0);
    endfunction

    function automatic logic [27:0] exp_static(input logic [15:0] v, input int slot,
                                               input logic [3:0] b, input logic lz);
        logic [27:0] r;
        r = '1;
        if (slot < (int'(b) + 1) * UNIT) begin
            for (int n = 0; n < DIG; n++) begin
                if (!is_blank(v, n, lz)) r[7*n +: 7] = ~font(v[4*n +: 4]);
            end
        end
        return r;
    endfunction

    // Returns {dig_sel, dp_mux, seg_mux} as seen on the pins.
    function automatic logic [11:0] exp_mux(input logic [15:0] v, input logic [3:0] d, input int slot,
                                            input int idx, input logic [3:0] b, input logic lz);
        logic [3:0] sel;
        logic       dpo;
        logic [6:0] seg;
        sel = 4'hF;
        dpo = 1'b1;
        seg = 7'h7F;
        if (slot < (int'(b) + 1) * UNIT) begin
            sel = ~(4'b0001 << idx);
            dpo = ~d[idx];
            if (!is_blank(v, idx, lz)) seg = ~font(v[4*idx +: 4]);
        end
        return {sel, dpo, seg};
    endfunction

    int unsigned m_t;          // cycles since reset release = linear frame position
    logic [15:0] m_val, m_pval, n_val;
    logic [3:0]  m_dp, m_pdp, n_dp;
    logic        m_pend, m_bnd;
    logic [27:0] e_static;
    logic [11:0] e_mux;
    logic        e_ack, e_fs;

    assign m_bnd = ((m_t % FRAME) == FRAME - 1);

    always_comb begin
        n_val = m_val;
        n_dp  = m_dp;
        if (m_bnd && value_we) begin
            n_val = value;
            n_dp  = dp;
        end else if (m_bnd && m_pend) begin
            n_val = m_pval;
            n_dp  = m_pdp;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t      <= 0;
            m_val    <= '0;
            m_dp     <= '0;
            m_pval   <= '0;
            m_pdp    <= '0;
            m_pend   <= 1'b0;
            e_static <= '1;
            e_mux    <= '1;
            e_ack    <= 1'b0;
            e_fs     <= 1'b0;
        end else begin
            m_t      <= m_t + 1;
            m_val    <= n_val;
            m_dp     <= n_dp;
            if (value_we) begin
                m_pval <= value;
                m_pdp  <= dp;
            end
            m_pend   <= !m_bnd && (m_pend || value_we);
            e_static <= exp_static(n_val, int'(m_t % DIV), brightness, lz_blank);
            e_mux    <= exp_mux(n_val, n_dp, int'(m_t % DIV), int'((m_t / DIV) % DIG), brightness, lz_blank);
            e_ack    <= m_bnd && (value_we || m_pend);
            e_fs     <= ((m_t % FRAME) == 0);
        end
    end

    // Every cycle, every pin of both instances against the model.
    always @(negedge clk) begin
        check_val("s_seg_static", seg_static_s, e_static);
        check_val("s_seg_mux",    seg_mux_s,    7'h7F);
        check_val("s_dp_mux",     dp_mux_s,     1'b1);
        check_val("s_dig_sel",    dig_sel_s,    4'hF);
        check_val("s_update_ack", ack_s,        e_ack);
        check_val("s_frame_strobe", fs_s,       e_fs);
        check_val("m_seg_static", seg_static_m, 28'hFFFFFFF);
        check_val("m_seg_mux",    seg_mux_m,    e_mux[6:0]);
        check_val("m_dp_mux",     dp_mux_m,     e_mux[7]);
        check_val("m_dig_sel",    dig_sel_m,    e_mux[11:8]);
        check_val("m_update_ack", ack_m,        e_ack);
        check_val("m_frame_strobe", fs_m,       e_fs);
    end

    // ---------------- directed and random stimulus ----------------
    task automatic write_val(input logic [15:0] v, input logic [3:0] d);
        value    = v;
        dp       = d;
        value_we = 1'b1;
        @(negedge clk);
        value_we = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (ack_s !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, ack_s, 1'b1);
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (fs_m !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, fs_m, 1'b1);
    endtask

    logic [3:0] order [4];
    int active_cnt, ack_cnt, bad_cnt, wait_n;

    initial begin
        order = '{4'hE, 4'hD, 4'hB, 4'h7};
        reset_n = 1'b0; value = '0; dp = '0; value_we = 1'b0;
        lz_blank = 1'b0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        check_val("rst_seg_static", seg_static_s, 28'hFFFFFFF);
        check_val("rst_seg_mux", seg_mux_m, 7'h7F);
        check_val("rst_dig_sel", dig_sel_m, 4'hF);
        check_val("rst_ack", ack_s, 1'b0);

        reset_n = 1'b1;
        @(negedge clk);
        check_val("first_frame_strobe", fs_m, 1'b1);

        // static decode
        write_val(16'h1A3F, 4'h5);
        wait_ack("ack_1A3F");
        check_val("dec_1A3F", seg_static_s, E_1A3F);

        // leading-zero blanking
        lz_blank = 1'b1;
        write_val(16'h0040, 4'h0);
        wait_ack("ack_0040");
        check_val("lz_0040", seg_static_s, E_0040);
        write_val(16'h0000, 4'h0);
        wait_ack("ack_0000");
        check_val("lz_0000", seg_static_s, E_0000);

        // multiplexed PWM: 4 of 16 cycles lit, digits in order 0..3
        lz_blank   = 1'b0;
        brightness = 4'd3;
        @(negedge clk);
        wait_fs("fs_pwm");
        active_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (dig_sel_m != 4'hF) active_cnt++;
            if (k % DIV == 0) check_val("pwm_order", dig_sel_m, order[k / DIV]);
            @(negedge clk);
        end
        check_val("pwm_active_cycles", active_cnt, 16);

        // two writes in one frame: one ack, last write wins
        brightness = 4'd15;
        wait_fs("fs_coalesce");
        repeat (4) @(negedge clk);
        write_val(16'h1234, 4'h0);
        repeat (10) @(negedge clk);
        write_val(16'h5678, 4'h0);
        ack_cnt = 0;
        bad_cnt = 0;
        for (int k = 0; k < 90; k++) begin
            if (ack_s === 1'b1) ack_cnt++;
            if (seg_static_s === E_1234) bad_cnt++;
            @(negedge clk);
        end
        check_val("coalesce_acks", ack_cnt, 1);
        check_val("coalesce_no_1234", bad_cnt, 0);
        check_val("coalesce_5678", seg_static_s, E_5678);

        // write on the boundary cycle bypasses pending
        wait_n = 0;
        while ((m_t % FRAME) != FRAME - 1 && wait_n < 2 * FRAME) begin
            @(negedge clk);
            wait_n++;
        end
        write_val(16'h9999, 4'hA);
        check_val("bypass_ack", ack_s, 1'b1);
        check_val("bypass_9999", seg_static_s, E_9999);
        ack_cnt = 0;
        for (int k = 0; k < FRAME + 8; k++) begin
            @(negedge clk);
            if (ack_s === 1'b1) ack_cnt++;
        end
        check_val("bypass_no_second_ack", ack_cnt, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            value    = 16'($urandom) >> $urandom_range(0, 16);
            dp       = 4'($urandom);
            value_we = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) lz_blank = 1'($urandom);
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            @(negedge clk);
        end
        value_we = 1'b0;

        // asynchronous reset in the middle of a frame
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_val("async_rst_seg_mux", seg_mux_m, 7'h7F);
        check_val("async_rst_dig_sel", dig_sel_m, 4'hF);
        check_val("async_rst_ack", ack_s, 1'b0);
        check_val("async_rst_seg_static", seg_static_s, 28'hFFFFFFF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_frame_strobe", fs_s, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
